mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency synchronous memory between two requesters: the fetch stage (instruction reads) and the memory stage (loads and stores).
- Sits between fetch_cycle / memory-cycle logic and the unified memory.
- Issues one transaction at a time, returns read data with a valid strobe, and produces per-requester stall signals for the pipeline control.
- Accepts a fetch-flush input (branch taken in Execute) so that a stale in-flight fetch response is discarded.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width; must be a multiple of 8.
- LATENCY, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..7.
- STARVE_MAX, 4, maximum consecutive memory-stage grants while fetch is waiting; the next grant is then forced to fetch. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch read request; held with if_addr stable until if_valid
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  discard any in-flight or same-cycle fetch (PCSrcE)
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle strobe; if_rdata is valid
- if_stall  out  1  fetch must hold PC
- ls_req  in  1  load/store request; held stable until ls_valid
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_be  in  DATA_W/8  byte enables for stores
- ls_rdata  out  DATA_W  load data
- ls_valid  out  1  one-cycle strobe; load data valid or store complete
- ls_stall  out  1  memory stage must hold
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid LATENCY cycles after mem_en
- perf_if_stall  out  32  fetch stall-cycle count (optional feature)
- perf_ls_stall  out  32  load/store stall-cycle count (optional feature)

Behaviour:
- FSM states:
  - IDLE: no transaction outstanding.
  - RD_IF: fetch read outstanding.
  - RD_LS: load outstanding.
  - WR_LS: store completing.
- Reset:
  - State goes to IDLE; wait counter = 0; starve counter = 0; discard flag = 0.
  - All mem_* outputs, if_valid, ls_valid, if_rdata and ls_rdata are 0.
  - Perf counters are 0.
- Grants are issued only in IDLE, combinationally, in the same cycle as the request.
  - Drive mem_en=1 and mem_addr/mem_we/mem_wdata/mem_be from the winner.
  - Register the next state.
  - mem_en is 0 in every other state.
  - Throughput is one transaction per LATENCY+1 cycles.
- Arbitration in IDLE:
  - ls_req has priority over if_req.
  - Exception: if starve_cnt == STARVE_MAX and if_req=1, fetch wins.
  - starve_cnt increments on each ls grant while if_req=1.
  - starve_cnt clears on a fetch grant, or on any cycle with if_req=0.
  - starve_cnt saturates at STARVE_MAX.
- Fetch grant:
  - Not issued if if_flush=1 in that cycle, because the address is being redirected.
  - Goes to RD_IF and loads wait_cnt = LATENCY-1.
  - In RD_IF, wait_cnt decrements. At 0, if_valid=1 and if_rdata=mem_rdata for one cycle, then return to IDLE.
- Load grant: same as fetch, via RD_LS; ls_valid and ls_rdata are driven at completion.
- Store grant: mem_we=1 in the grant cycle; goes to WR_LS for exactly 1 cycle, with ls_valid=1 there; returns to IDLE. LATENCY does not apply to stores.
- Flush:
  - if_flush=1 during RD_IF (including the completion cycle) sets the discard flag.
  - The completion cycle then drives if_valid=0.
  - The FSM still waits out LATENCY, so the memory is never re-issued early.
  - The discard flag clears on return to IDLE.
  - if_flush has no effect on load/store transactions.
- Stalls (combinational):
  - if_stall = if_req & ~if_valid.
  - ls_stall = ls_req & ~ls_valid.
- Outputs outside completion cycles: if_rdata and ls_rdata hold their last valid value and update only on their own valid strobe.
- Reset asserted mid-transaction: the in-flight response is dropped, no valid strobe is produced, and the FSM restarts in IDLE.
- Simultaneous if_req and ls_req with an ls store: the store wins; fetch is granted in the following IDLE cycle unless another ls_req arrives and starve_cnt < STARVE_MAX.

Optional Feature:
- ARB_PERF_CNT_EN defined:
  - perf_if_stall increments on every cycle with if_stall=1.
  - perf_ls_stall increments on every cycle with ls_stall=1.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on rst.
- Not defined: both ports are tied to 0 and no counter flops are inferred.

Test Plan:
- Single fetch, LATENCY=1:
  - Stimulus: if_req=1, if_addr=0x00000000; memory returns 0x00500293.
  - Expected: mem_en=1 in cycle 0; if_valid=1 with if_rdata=0x00500293 in cycle 1; if_stall=1 in cycle 0 only.
- Contention:
  - Stimulus: if_req and ls_req (load, 0x100) both asserted in cycle 0.
  - Expected: load is granted at cycle 0 and ls_valid is seen at cycle 1; fetch is granted at cycle 2 and if_valid is seen at cycle 3.
- Starvation, STARVE_MAX=4:
  - Stimulus: continuous ls_req loads with if_req held.
  - Expected: exactly 4 ls grants, then a fetch grant, then ls resumes.
- Flush:
  - Stimulus: LATENCY=3; fetch to 0x20; if_flush=1 one cycle after the grant.
  - Expected: no if_valid; next grant is no earlier than 4 cycles after the original.
- Store:
  - Stimulus: ls_we=1, ls_addr=0x40, ls_wdata=0xDEADBEEF, ls_be=4'b0011.
  - Expected: mem_we=1, mem_be=0011 for one cycle; ls_valid the next cycle; a load of 0x40 returns 0x0000BEEF from the bench memory model.
- Reset mid-read:
  - Stimulus: LATENCY=3; rst=1 in cycle 1 after a fetch grant.
  - Expected: no if_valid; all outputs 0; the next if_req is granted in the first cycle after rst deasserts.
  - With ARB_PERF_CNT_EN defined, also check perf_if_stall == 0 after reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported fixed-latency memory between instruction fetch and load/store.
// Optional stall-cycle counters are compiled in when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_flush,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_valid,
  output logic                  if_stall,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_be,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  ls_valid,
  output logic                  ls_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [31:0]           perf_if_stall,
  output logic [31:0]           perf_ls_stall
);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_LS, WR_LS} state_e;

  localparam logic [2:0] WAIT_INIT  = 3'(LATENCY - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [2:0]        wait_q, wait_d;
  logic [3:0]        starve_q, starve_d;
  logic              discard_q, discard_d;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
  logic              grant_if, grant_ls, starved;

  assign starved = (starve_q == STARVE_LIM) && if_req;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    discard_d = discard_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if_valid  = 1'b0;
    ls_valid  = 1'b0;
    grant_if  = 1'b0;
    grant_ls  = 1'b0;
    // Nothing is granted or completed while rst is high, so a reset cycle never leaks a strobe.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          grant_if = if_req && !if_flush && (!ls_req || starved);
          grant_ls = ls_req && !grant_if;
          if (grant_if) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            state_d   = RD_IF;
            wait_d    = WAIT_INIT;
            discard_d = 1'b0;
          end else if (grant_ls) begin
            mem_en    = 1'b1;
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            mem_be    = ls_be;
            state_d   = ls_we ? WR_LS : RD_LS;
            wait_d    = WAIT_INIT;
          end
        end
        RD_IF: begin
          discard_d = discard_q || if_flush;
          if (wait_q == 3'd0) begin
            if_valid  = !(discard_q || if_flush);
            state_d   = IDLE;
            discard_d = 1'b0;
          end else begin
            wait_d = wait_q - 3'd1;
          end
        end
        RD_LS: begin
          if (wait_q == 3'd0) begin
            ls_valid = 1'b1;
            state_d  = IDLE;
          end else begin
            wait_d = wait_q - 3'd1;
          end
        end
        WR_LS: begin
          ls_valid = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req || grant_if) begin
      starve_d = '0;
    end else if (grant_ls && starve_q != STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      starve_q   <= '0;
      discard_q  <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      starve_q  <= starve_d;
      discard_q <= discard_d;
      if (if_valid) if_rdata_q <= mem_rdata;
      if (ls_valid && state_q == RD_LS) ls_rdata_q <= mem_rdata;
    end
  end

  assign if_rdata = if_valid ? mem_rdata : if_rdata_q;
  assign ls_rdata = (ls_valid && state_q == RD_LS) ? mem_rdata : ls_rdata_q;
  assign if_stall = if_req && !if_valid;
  assign ls_stall = ls_req && !ls_valid;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_ls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_q <= '0;
      perf_ls_q <= '0;
    end else begin
      if (if_stall && perf_if_q != '1) perf_if_q <= perf_if_q + 32'd1;
      if (ls_stall && perf_ls_q != '1) perf_ls_q <= perf_ls_q + 32'd1;
    end
  end

  assign perf_if_stall = perf_if_q;
  assign perf_ls_stall = perf_ls_q;
`else
  assign perf_if_stall = '0;
  assign perf_ls_stall = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance A runs LATENCY=1, instance B runs LATENCY=3.
module tb_mem_port_arbiter;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          chk_data;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_rst, a_if_req, a_if_flush, a_if_valid, a_if_stall;
  logic        a_ls_req, a_ls_we, a_ls_valid, a_ls_stall;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_if_addr, a_if_rdata, a_ls_addr, a_ls_wdata, a_ls_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata, a_perf_if, a_perf_ls;
  logic [3:0]  a_ls_be, a_mem_be;

  logic        b_rst, b_if_req, b_if_flush, b_if_valid, b_if_stall;
  logic        b_ls_req, b_ls_we, b_ls_valid, b_ls_stall;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_if_addr, b_if_rdata, b_ls_addr, b_ls_wdata, b_ls_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata, b_perf_if, b_perf_ls;
  logic [3:0]  b_ls_be, b_mem_be;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .STARVE_MAX(4)) u_dut_a (
    .clk(clk), .rst(a_rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_flush(a_if_flush),
    .if_rdata(a_if_rdata), .if_valid(a_if_valid), .if_stall(a_if_stall),
    .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_addr(a_ls_addr), .ls_wdata(a_ls_wdata),
    .ls_be(a_ls_be), .ls_rdata(a_ls_rdata), .ls_valid(a_ls_valid), .ls_stall(a_ls_stall),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_be(a_mem_be), .mem_rdata(a_mem_rdata),
    .perf_if_stall(a_perf_if), .perf_ls_stall(a_perf_ls)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3), .STARVE_MAX(4)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_flush(b_if_flush),
    .if_rdata(b_if_rdata), .if_valid(b_if_valid), .if_stall(b_if_stall),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
    .ls_be(b_ls_be), .ls_rdata(b_ls_rdata), .ls_valid(b_ls_valid), .ls_stall(b_ls_stall),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_be(b_mem_be), .mem_rdata(b_mem_rdata),
    .perf_if_stall(b_perf_if), .perf_ls_stall(b_perf_ls)
  );

  // Memory models: A returns data one cycle after mem_en, B three cycles after.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] a_pipe;
  logic [31:0] b_pipe [3];

  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) begin
        for (int b = 0; b < 4; b++)
          if (a_mem_be[b]) mem_a[a_mem_addr[9:2]][b*8 +: 8] = a_mem_wdata[b*8 +: 8];
      end else begin
        a_pipe <= mem_a[a_mem_addr[9:2]];
      end
    end
  end
  assign a_mem_rdata = a_pipe;

  always @(posedge clk) begin
    b_pipe[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr[9:2]] : 32'h0;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_mem_rdata = b_pipe[2];

  exp_t q_ag[$], q_aif[$], q_als[$], q_bg[$], q_bif[$];

  function automatic exp_t mk(int c, logic we, logic [31:0] addr, logic [31:0] data,
                              logic [3:0] be, bit chk_data);
    exp_t e;
    e.cyc = c; e.we = we; e.addr = addr; e.data = data; e.be = be; e.chk_data = chk_data;
    return e;
  endfunction

  function automatic void gcheck(string nm, bit have, exp_t e, logic we, logic [31:0] addr,
                                 logic [31:0] wdata, logic [3:0] be);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s: unexpected grant at cycle %0d addr=%h we=%b", nm, cyc, addr, we);
    end else if (cyc != e.cyc || we !== e.we || addr !== e.addr ||
                 (e.we && (wdata !== e.data || be !== e.be))) begin
      errors++;
      $display("FAIL %s: got cyc=%0d we=%b addr=%h wdata=%h be=%b, expected cyc=%0d we=%b addr=%h wdata=%h be=%b",
               nm, cyc, we, addr, wdata, be, e.cyc, e.we, e.addr, e.data, e.be);
    end
  endfunction

  function automatic void vcheck(string nm, bit have, exp_t e, logic [31:0] data);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s: unexpected valid at cycle %0d data=%h", nm, cyc, data);
    end else if (cyc != e.cyc || (e.chk_data && data !== e.data)) begin
      errors++;
      $display("FAIL %s: got cyc=%0d data=%h, expected cyc=%0d data=%h", nm, cyc, data, e.cyc, e.data);
    end
  endfunction

  // Monitors pop one expectation per observed grant/strobe.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   have;
    if (a_mem_en) begin
      have = q_ag.size() > 0; if (have) e = q_ag.pop_front();
      gcheck("a_grant", have, e, a_mem_we, a_mem_addr, a_mem_wdata, a_mem_be);
    end
    if (a_if_valid) begin
      have = q_aif.size() > 0; if (have) e = q_aif.pop_front();
      vcheck("a_if_valid", have, e, a_if_rdata);
    end
    if (a_ls_valid) begin
      have = q_als.size() > 0; if (have) e = q_als.pop_front();
      vcheck("a_ls_valid", have, e, a_ls_rdata);
    end
    if (b_mem_en) begin
      have = q_bg.size() > 0; if (have) e = q_bg.pop_front();
      gcheck("b_grant", have, e, b_mem_we, b_mem_addr, b_mem_wdata, b_mem_be);
    end
    if (b_if_valid) begin
      have = q_bif.size() > 0; if (have) e = q_bif.pop_front();
      vcheck("b_if_valid", have, e, b_if_rdata);
    end
    if (b_ls_valid) begin
      checks++; errors++;
      $display("FAIL b_ls_valid: unexpected strobe at cycle %0d", cyc);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_v(input int which, input string nm);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      case (which)
        0:       seen = a_if_valid;
        1:       seen = a_ls_valid;
        2:       seen = b_if_valid;
        default: seen = 0;
      endcase
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: no valid strobe within 20 cycles", nm);
    end
    step();
  endtask

  task automatic a_fetch(input logic [31:0] addr);
    a_if_req = 1'b1; a_if_addr = addr;
    wait_v(0, "a_fetch_wait");
  endtask

  task automatic a_ls(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be);
    a_ls_req = 1'b1; a_ls_we = we; a_ls_addr = addr; a_ls_wdata = wdata; a_ls_be = be;
    wait_v(1, "a_ls_wait");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[0]  = 32'h00500293;
    mem_a[1]  = 32'h00A00313;
    mem_a[2]  = 32'h00B00393;
    mem_a[64] = 32'h12345678;
    for (int i = 0; i < 6; i++) mem_a[65+i] = 32'h10000000 + i;
    mem_b[8]  = 32'hCAFE0001;
    mem_b[9]  = 32'hCAFE0002;
    mem_b[10] = 32'hCAFE0003;
    mem_b[11] = 32'hCAFE0004;

    a_rst = 1; a_if_req = 0; a_if_addr = 0; a_if_flush = 0;
    a_ls_req = 0; a_ls_we = 0; a_ls_addr = 0; a_ls_wdata = 0; a_ls_be = 0;
    b_rst = 1; b_if_req = 0; b_if_addr = 0; b_if_flush = 0;
    b_ls_req = 0; b_ls_we = 0; b_ls_addr = 0; b_ls_wdata = 0; b_ls_be = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_mem_en", 32'(a_mem_en), 32'd0);
    chk("rst_a_mem_addr", a_mem_addr, 32'd0);
    chk("rst_a_if_valid", 32'(a_if_valid), 32'd0);
    chk("rst_a_ls_valid", 32'(a_ls_valid), 32'd0);
    chk("rst_a_if_rdata", a_if_rdata, 32'd0);
    chk("rst_a_ls_rdata", a_ls_rdata, 32'd0);
    chk("rst_b_mem_en", 32'(b_mem_en), 32'd0);
    step();
    a_rst = 0; b_rst = 0;
    step();

    // Single fetch
    t = cyc;
    q_ag.push_back(mk(t, 0, 32'h0, 32'h0, 4'h0, 0));
    q_aif.push_back(mk(t + 1, 0, 32'h0, 32'h00500293, 4'h0, 1));
    a_if_req = 1; a_if_addr = 32'h0;
    @(negedge clk); chk("if_stall_cycle0", 32'(a_if_stall), 32'd1);
    @(negedge clk); chk("if_stall_cycle1", 32'(a_if_stall), 32'd0);
    step();
    a_if_req = 0;
    step(); step();

    // Contention: load wins, fetch follows
    t = cyc;
    q_ag.push_back(mk(t,     0, 32'h100, 32'h0, 4'h0, 0));
    q_ag.push_back(mk(t + 2, 0, 32'h4,   32'h0, 4'h0, 0));
    q_als.push_back(mk(t + 1, 0, 32'h0, 32'h12345678, 4'h0, 1));
    q_aif.push_back(mk(t + 3, 0, 32'h0, 32'h00A00313, 4'h0, 1));
    fork
      begin a_ls(0, 32'h100, 32'h0, 4'h0); a_ls_req = 0; end
      begin a_fetch(32'h4); a_if_req = 0; end
    join
    step(); step();

    // Starvation: four loads, forced fetch, loads resume
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      q_ag.push_back(mk(t + 2*i, 0, 32'h104 + 4*i, 32'h0, 4'h0, 0));
      q_als.push_back(mk(t + 2*i + 1, 0, 32'h0, 32'h10000000 + i, 4'h0, 1));
    end
    q_ag.push_back(mk(t + 8, 0, 32'h8, 32'h0, 4'h0, 0));
    q_aif.push_back(mk(t + 9, 0, 32'h0, 32'h00B00393, 4'h0, 1));
    for (int i = 4; i < 6; i++) begin
      q_ag.push_back(mk(t + 2*i + 2, 0, 32'h104 + 4*i, 32'h0, 4'h0, 0));
      q_als.push_back(mk(t + 2*i + 3, 0, 32'h0, 32'h10000000 + i, 4'h0, 1));
    end
    fork
      begin a_fetch(32'h8); a_if_req = 0; end
      begin
        for (int i = 0; i < 6; i++) a_ls(0, 32'h104 + 4*i, 32'h0, 4'h0);
        a_ls_req = 0;
      end
    join
    step(); step();

    // Store with partial byte enables, then read back
    t = cyc;
    q_ag.push_back(mk(t, 1, 32'h40, 32'hDEADBEEF, 4'b0011, 0));
    q_als.push_back(mk(t + 1, 0, 32'h0, 32'h0, 4'h0, 0));
    q_ag.push_back(mk(t + 2, 0, 32'h40, 32'h0, 4'h0, 0));
    q_als.push_back(mk(t + 3, 0, 32'h0, 32'h0000BEEF, 4'h0, 1));
    a_ls(1, 32'h40, 32'hDEADBEEF, 4'b0011);
    a_ls(0, 32'h40, 32'h0, 4'h0);
    a_ls_req = 0;
    step();
    @(negedge clk);
    chk("a_if_rdata_hold", a_if_rdata, 32'h00B00393);
    chk("a_ls_rdata_hold", a_ls_rdata, 32'h0000BEEF);
    step();

    // Flush one cycle after a fetch grant at LATENCY=3
    t = cyc;
    q_bg.push_back(mk(t,     0, 32'h20, 32'h0, 4'h0, 0));
    q_bg.push_back(mk(t + 4, 0, 32'h24, 32'h0, 4'h0, 0));
    q_bif.push_back(mk(t + 7, 0, 32'h0, 32'hCAFE0002, 4'h0, 1));
    b_if_req = 1; b_if_addr = 32'h20;
    step();
    b_if_flush = 1; b_if_req = 0;
    step();
    b_if_flush = 0; b_if_req = 1; b_if_addr = 32'h24;
    wait_v(2, "b_fetch_after_flush");
    b_if_req = 0;
    step(); step();

    // Reset in the middle of a LATENCY=3 fetch
    t = cyc;
    q_bg.push_back(mk(t,     0, 32'h28, 32'h0, 4'h0, 0));
    q_bg.push_back(mk(t + 3, 0, 32'h2C, 32'h0, 4'h0, 0));
    q_bif.push_back(mk(t + 6, 0, 32'h0, 32'hCAFE0004, 4'h0, 1));
    b_if_req = 1; b_if_addr = 32'h28;
    step();
    b_rst = 1; b_if_req = 0;
    step();
    @(negedge clk);
    chk("rst_mid_mem_en", 32'(b_mem_en), 32'd0);
    chk("rst_mid_mem_addr", b_mem_addr, 32'd0);
    chk("rst_mid_if_valid", 32'(b_if_valid), 32'd0);
    chk("rst_mid_if_rdata", b_if_rdata, 32'd0);
    chk("rst_mid_ls_rdata", b_ls_rdata, 32'd0);
    chk("rst_mid_if_stall", 32'(b_if_stall), 32'd0);
`ifdef ARB_PERF_CNT_EN
    chk("rst_mid_perf_if", b_perf_if, 32'd0);
`endif
    step();
    b_rst = 0; b_if_req = 1; b_if_addr = 32'h2C;
    wait_v(2, "b_fetch_after_rst");
    b_if_req = 0;

    repeat (4) step();
    chk("q_a_grant_left", 32'(q_ag.size()), 32'd0);
    chk("q_a_if_left", 32'(q_aif.size()), 32'd0);
    chk("q_a_ls_left", 32'(q_als.size()), 32'd0);
    chk("q_b_grant_left", 32'(q_bg.size()), 32'd0);
    chk("q_b_if_left", 32'(q_bif.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
